// File: rtl/i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// i2c_slave_rx -- write-only I2C slave receiver.
//
// Watches pre-synchronised SDA/SCL samples (current and one clk earlier),
// detects START/STOP, matches a 7-bit address (write only), ACKs the address
// and every following data byte, and presents each data byte on rx_data with
// a one-clk rx_valid strobe.
//
// Optional feature: define I2C_RX_GENCALL_EN to also accept the general-call
// address byte 8'h00.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   sda_in       synchronised SDA, current sample
//   scl_in       synchronised SCL, current sample
//   past_sda_in  SDA sample one clk earlier
//   past_scl_in  SCL sample one clk earlier
//   sda_oe       1 = pad pulls SDA low (ACK)
//   rx_data      last received data byte
//   rx_valid     one-clk strobe when rx_data updates
//   start_det    one-clk strobe on START / repeated START
//   stop_det     one-clk strobe on STOP
//   busy         1 from START until STOP
// ---------------------------------------------------------------------------
module i2c_slave_rx #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sda_in,
    input  logic       scl_in,
    input  logic       past_sda_in,
    input  logic       past_scl_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_sda_oe, w_oe_nxt;
    logic [7:0] r_rx_data, w_data_nxt;
    logic       r_rx_valid, w_valid_nxt;
    logic       r_start_det, w_start_nxt;
    logic       r_stop_det, w_stop_nxt;
    logic       r_busy, w_busy_nxt;

    logic       w_rise, w_fall, w_start, w_stop;
    logic [7:0] w_byte;
    logic       w_match;

    assign w_rise  =  scl_in & ~past_scl_in;
    assign w_fall  = ~scl_in &  past_scl_in;
    assign w_start =  scl_in &  past_scl_in &  past_sda_in & ~sda_in;
    assign w_stop  =  scl_in &  past_scl_in & ~past_sda_in &  sda_in;

    // Byte as it will look once the current sample is shifted in.
    assign w_byte  = {r_shift[6:0], sda_in};

`ifdef I2C_RX_GENCALL_EN
    assign w_match = (w_byte == {DEV_ADDR, 1'b0}) || (w_byte == 8'h00);
`else
    assign w_match = (w_byte == {DEV_ADDR, 1'b0});
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_shift     <= 8'h00;
            r_sda_oe    <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_sda_oe    <= w_oe_nxt;
            r_rx_data   <= w_data_nxt;
            r_rx_valid  <= w_valid_nxt;
            r_start_det <= w_start_nxt;
            r_stop_det  <= w_stop_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_oe_nxt    = r_sda_oe;
        w_data_nxt  = r_rx_data;
        w_valid_nxt = 1'b0;
        w_start_nxt = 1'b0;
        w_stop_nxt  = 1'b0;
        w_busy_nxt  = r_busy;

        if (w_start) begin
            w_state_nxt = ADDR;
            w_cnt_nxt   = 3'd0;
            w_shift_nxt = 8'h00;
            w_oe_nxt    = 1'b0;
            w_start_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = IDLE;
            w_oe_nxt    = 1'b0;
            w_stop_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ADDR, DATA: begin
                    if (w_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (r_state == DATA) begin
                                w_data_nxt  = w_byte;
                                w_valid_nxt = 1'b1;
                                w_state_nxt = DATA_ACK;
                            end else begin
                                w_state_nxt = w_match ? ADDR_ACK : IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // First fall ends the 8th bit and starts the pull-down;
                    // the next fall ends the 9th (ACK) clock and releases it.
                    if (w_fall) begin
                        if (!r_sda_oe) begin
                            w_oe_nxt = 1'b1;
                        end else begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = DATA;
                            w_cnt_nxt   = 3'd0;
                        end
                    end
                end
                IGNORE: begin
                    w_oe_nxt = 1'b0;
                end
                default: begin
                    w_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = r_sda_oe;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign start_det = r_start_det;
    assign stop_det  = r_stop_det;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_rx -- directed bench for i2c_slave_rx.
// Bus is modelled as wired-AND of the master SDA and the slave pull-down;
// the one-clk-earlier samples come from a small delay flop.
// ---------------------------------------------------------------------------
module tb_i2c_slave_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       past_scl = 1'b1;
    logic       past_sda = 1'b1;
    logic       w_sda;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, start_det, stop_det, busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid = 0;
    int n_start = 0;
    int n_stop = 0;
    logic [7:0] rx_log[$];

`ifdef I2C_RX_GENCALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    always #5 clk = ~clk;

    assign w_sda = sda_m & ~sda_oe;

    always @(posedge clk) begin
        past_scl <= scl_m;
        past_sda <= w_sda;
    end

    i2c_slave_rx #(.DEV_ADDR(7'h50)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sda_in     (w_sda),
        .scl_in     (scl_m),
        .past_sda_in(past_sda),
        .past_scl_in(past_scl),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            rx_log.push_back(rx_data);
        end
        if (start_det) n_start++;
        if (stop_det)  n_stop++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nwait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; nwait(4);
        sda_m = 1'b0; nwait(4);
        scl_m = 1'b0; nwait(2);
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; nwait(2);
        scl_m = 1'b1; nwait(4);
        sda_m = 1'b0; nwait(4);
        scl_m = 1'b0; nwait(2);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; nwait(2);
        scl_m = 1'b1; nwait(4);
        sda_m = 1'b1; nwait(4);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    nwait(2);
        scl_m = 1'b1; nwait(4);
        scl_m = 1'b0; nwait(2);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Ninth clock: master releases SDA; slave pull-down is sampled mid-high.
    task automatic ack_slot(input string tag, input logic exp);
        sda_m = 1'b1; nwait(2);
        check({tag, "_lo"}, sda_oe, exp);
        scl_m = 1'b1; nwait(2);
        check(tag, sda_oe, exp);
        nwait(2);
        scl_m = 1'b0; nwait(2);
        check({tag, "_rel"}, sda_oe, 1'b0);
    endtask

    int v0, s0, p0;

    initial begin
        // Reset state
        nwait(3);
        check("rst_oe", sda_oe, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_start", start_det, 0);
        check("rst_stop", stop_det, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        nwait(4);

        // Addressed write of 0xA5
        v0 = n_valid; s0 = n_start; p0 = n_stop;
        bus_start();
        check("t1_busy", busy, 1);
        send_byte(8'hA0); ack_slot("t1_aack", 1'b1);
        send_byte(8'hA5); ack_slot("t1_dack", 1'b1);
        bus_stop();
        check("t1_nvalid", n_valid - v0, 1);
        check("t1_data", rx_data, 8'hA5);
        check("t1_nstart", n_start - s0, 1);
        check("t1_nstop", n_stop - p0, 1);
        check("t1_busy_end", busy, 0);

        // Wrong address 0x51: ignored until STOP
        v0 = n_valid;
        bus_start();
        send_byte(8'hA2); ack_slot("t2_aack", 1'b0);
        send_byte(8'h00); ack_slot("t2_dack", 1'b0);
        check("t2_busy", busy, 1);
        bus_stop();
        check("t2_nvalid", n_valid - v0, 0);
        check("t2_busy_end", busy, 0);
        check("t2_data_hold", rx_data, 8'hA5);

        // Read request to own address: NACK
        v0 = n_valid;
        bus_start();
        send_byte(8'hA1); ack_slot("t3_aack", 1'b0);
        send_byte(8'hFF); ack_slot("t3_dack", 1'b0);
        bus_stop();
        check("t3_nvalid", n_valid - v0, 0);

        // Repeated START between two writes
        v0 = n_valid; s0 = n_start; p0 = n_stop;
        rx_log.delete();
        bus_start();
        send_byte(8'hA0); ack_slot("t4_aack1", 1'b1);
        send_byte(8'h12); ack_slot("t4_dack1", 1'b1);
        bus_rstart();
        send_byte(8'hA0); ack_slot("t4_aack2", 1'b1);
        send_byte(8'h34); ack_slot("t4_dack2", 1'b1);
        bus_stop();
        check("t4_nvalid", n_valid - v0, 2);
        check("t4_nstart", n_start - s0, 2);
        check("t4_nstop", n_stop - p0, 1);
        if (rx_log.size() == 2) begin
            check("t4_byte0", rx_log[0], 8'h12);
            check("t4_byte1", rx_log[1], 8'h34);
        end else begin
            check("t4_logsize", rx_log.size(), 2);
        end

        // Asynchronous reset while ACK is being driven
        bus_start();
        send_byte(8'hA0);
        sda_m = 1'b1; nwait(2);
        scl_m = 1'b1; nwait(2);
        check("t5_oe_before", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_oe_async", sda_oe, 0);
        check("t5_data", rx_data, 8'h00);
        check("t5_busy", busy, 0);
        check("t5_valid", rx_valid, 0);
        nwait(2);
        check("t5_start", start_det, 0);
        check("t5_stop", stop_det, 0);
        scl_m = 1'b0; nwait(2);
        rst_n = 1'b1; nwait(2);
        // No START yet: address byte must be ignored
        v0 = n_valid;
        send_byte(8'hA0); ack_slot("t5_nostart", 1'b0);
        check("t5_busy_idle", busy, 0);

        // General call address 0x00
        bus_start();
        send_byte(8'h00); ack_slot("t6_aack", GC);
        send_byte(8'h5A); ack_slot("t6_dack", GC);
        bus_stop();
        check("t6_nvalid", n_valid - v0, GC ? 1 : 0);
        check("t6_data", rx_data, GC ? 8'h5A : 8'h00);

        // Partial bytes cut by repeated START and by STOP are discarded
        v0 = n_valid;
        bus_start();
        send_byte(8'hA0); ack_slot("t7_aack1", 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        bus_rstart();
        check("t7_oe_rs", sda_oe, 0);
        send_byte(8'hA0); ack_slot("t7_aack2", 1'b1);
        send_byte(8'hC3); ack_slot("t7_dack", 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        bus_stop();
        check("t7_nvalid", n_valid - v0, 1);
        check("t7_data", rx_data, 8'hC3);
        check("t7_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
